// File: rtl/tt_um_jleugeri_ttt_scheduler_if.sv
// Bus between the token-processor stage scheduler and the array it sequences:
// stage status, processor/connection addressing and the three handshakes.
interface tt_um_jleugeri_ttt_scheduler_if #(
   parameter int NUM_PROCESSORS  = 16,
   parameter int NUM_CONNECTIONS = 64
);
   localparam int IDX_BITS  = $clog2(NUM_PROCESSORS);
   localparam int CONN_BITS = $clog2(NUM_CONNECTIONS);

   logic                 prog_mode;
   logic                 hold;
   logic [2:0]           stage;
   logic                 done;
   logic [IDX_BITS-1:0]  proc_idx;
   logic                 clear_buf;
   logic                 ext_valid;
   logic                 ext_last;
   logic                 ext_ready;
   logic                 spike;
   logic [CONN_BITS:0]   conn_first;
   logic [CONN_BITS:0]   conn_end;
   logic                 conn_valid;
   logic [CONN_BITS-1:0] conn_idx;
   logic                 update_en;
   logic                 out_valid;
   logic                 out_ready;

   // Scheduler side
   modport master (
      input  prog_mode, hold, ext_valid, ext_last, spike, conn_first, conn_end, out_ready,
      output stage, done, proc_idx, clear_buf, ext_ready, conn_valid, conn_idx, update_en,
             out_valid
   );

   // Processor-array / environment side
   modport slave (
      output prog_mode, hold, ext_valid, ext_last, spike, conn_first, conn_end, out_ready,
      input  stage, done, proc_idx, clear_buf, ext_ready, conn_valid, conn_idx, update_en,
             out_valid
   );
endinterface

// File: rtl/tt_um_jleugeri_ttt_scheduler.sv
// Stage sequencer for a token-processor array: RESET, then a repeating
// INPUT -> RECURRENT -> UPDATE -> OUTPUT cycle. Every output is decoded from
// registered state, so no input reaches an output combinationally.
module tt_um_jleugeri_ttt_scheduler #(
   parameter int NUM_PROCESSORS  = 16,
   parameter int NUM_CONNECTIONS = 64
) (
   input logic clk,
   input logic rst_n,
   tt_um_jleugeri_ttt_scheduler_if.master bus
);
   localparam int IDX_BITS  = $clog2(NUM_PROCESSORS);
   localparam int CONN_BITS = $clog2(NUM_CONNECTIONS);
   localparam logic [IDX_BITS-1:0] LAST_PROC = IDX_BITS'(NUM_PROCESSORS - 1);

   typedef enum logic [2:0] {
      StReset     = 3'd0,
      StInput     = 3'd1,
      StRecurrent = 3'd2,
      StUpdate    = 3'd3,
      StOutput    = 3'd4
   } stage_e;

   typedef enum logic {
      SubScan = 1'b0,
      SubWalk = 1'b1
   } sub_e;

   stage_e               stage_q, stage_d;
   sub_e                 sub_q, sub_d;
   logic                 done_q, done_d;
   logic                 cleared_q, cleared_d;
   logic [IDX_BITS-1:0]  proc_idx_q, proc_idx_d;
   logic [CONN_BITS-1:0] conn_idx_q, conn_idx_d;
   logic [CONN_BITS:0]   conn_end_q, conn_end_d;
   logic                 last_proc;
   logic                 last_conn;
   logic                 active;

   // State registers; reset abandons any stage in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_q    <= StReset;
         sub_q      <= SubScan;
         done_q     <= 1'b0;
         cleared_q  <= 1'b0;
         proc_idx_q <= '0;
         conn_idx_q <= '0;
         conn_end_q <= '0;
      end else begin
         stage_q    <= stage_d;
         sub_q      <= sub_d;
         done_q     <= done_d;
         cleared_q  <= cleared_d;
         proc_idx_q <= proc_idx_d;
         conn_idx_q <= conn_idx_d;
         conn_end_q <= conn_end_d;
      end
   end

   // Next-state: stage advance when done, otherwise the current stage's work
   always_comb begin
      stage_d    = stage_q;
      sub_d      = sub_q;
      done_d     = done_q;
      cleared_d  = cleared_q;
      proc_idx_d = proc_idx_q;
      conn_idx_d = conn_idx_q;
      conn_end_d = conn_end_q;
      last_proc  = (proc_idx_q == LAST_PROC);
      last_conn  = (({1'b0, conn_idx_q} + 1'b1) == conn_end_q);

      if (done_q) begin
         if (stage_q == StReset && bus.prog_mode) begin
            // Programming resumed: stay in RESET until it ends again
            done_d = 1'b0;
         end else if (!bus.hold) begin
            unique case (stage_q)
               StReset:     stage_d = StInput;
               StInput:     stage_d = StRecurrent;
               StRecurrent: stage_d = StUpdate;
               StUpdate:    stage_d = StOutput;
               StOutput:    stage_d = StInput;
               default:     stage_d = StReset;
            endcase
            done_d     = 1'b0;
            sub_d      = SubScan;
            cleared_d  = 1'b0;
            proc_idx_d = '0;
            conn_idx_d = '0;
         end
      end else begin
         unique case (stage_q)
            StReset: begin
               done_d = ~bus.prog_mode;
            end
            StInput: begin
               // First cycle clears the buffers; ext_ready is up from then on
               if (!cleared_q) begin
                  cleared_d = 1'b1;
               end else if (bus.ext_valid && bus.ext_last) begin
                  done_d = 1'b1;
               end
            end
            StRecurrent: begin
               if (sub_q == SubScan) begin
                  if (bus.spike && (bus.conn_first < bus.conn_end)) begin
                     conn_idx_d = bus.conn_first[CONN_BITS-1:0];
                     conn_end_d = bus.conn_end;
                     sub_d      = SubWalk;
                  end else if (last_proc) begin
                     done_d = 1'b1;
                  end else begin
                     proc_idx_d = proc_idx_q + 1'b1;
                  end
               end else begin
                  if (last_conn) begin
                     sub_d = SubScan;
                     if (last_proc) begin
                        done_d = 1'b1;
                     end else begin
                        proc_idx_d = proc_idx_q + 1'b1;
                     end
                  end else begin
                     conn_idx_d = conn_idx_q + 1'b1;
                  end
               end
            end
            StUpdate: begin
               if (last_proc) begin
                  done_d = 1'b1;
               end else begin
                  proc_idx_d = proc_idx_q + 1'b1;
               end
            end
            StOutput: begin
               if (bus.out_ready) begin
                  if (last_proc) begin
                     done_d = 1'b1;
                  end else begin
                     proc_idx_d = proc_idx_q + 1'b1;
                  end
               end
            end
            default: begin
               stage_d = StReset;
            end
         endcase
      end
   end

   // Outputs decoded from registered state only; strobes are silent once done
   always_comb begin
      active         = ~done_q;
      bus.stage      = stage_q;
      bus.done       = done_q;
      bus.proc_idx   = proc_idx_q;
      bus.conn_idx   = conn_idx_q;
      bus.clear_buf  = active && (stage_q == StInput) && !cleared_q;
      bus.ext_ready  = active && (stage_q == StInput) && cleared_q;
      bus.conn_valid = active && (stage_q == StRecurrent) && (sub_q == SubWalk);
      bus.update_en  = active && (stage_q == StUpdate);
      bus.out_valid  = active && (stage_q == StOutput);
   end
endmodule
